// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer driving one external full_adder slice (option: SERIAL_SUBTRACT_EN)
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign last_bit = (count == CW'(WIDTH - 1));

  // Subtraction is A + ~B + 1, so only the B operand and initial carry differ
`ifdef SERIAL_SUBTRACT_EN
  assign b_load = sub ? ~b_in : b_in;
  assign c_load = sub ? 1'b1  : cin;
`else
  assign b_load = b_in;
  assign c_load = cin;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and slice/status outputs; slice inputs come only from registers
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        fa_a = a_sr[0];
        fa_b = b_sr[0];
        fa_c = carry;
        if (last_bit) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand/result shifting; the published result takes the final bit on the FIN entry edge
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_load;
            carry  <= c_load;
            res_sr <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (last_bit) begin
            sum_out <= {fa_sum, res_sr[WIDTH-1:1]};
            cout    <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl with a behavioural full_adder slice
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             sub;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c;
  logic             fa_sum;
  logic             fa_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  int checks;
  int errors;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
`ifdef SERIAL_SUBTRACT_EN
    .sub     (sub),
`endif
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_c    (fa_c),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  // External one-bit full adder slice
  assign fa_sum  = fa_a ^ fa_b ^ fa_c;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input logic [7:0] exp_sum, input logic exp_cout, input string tag);
    int  nbusy;
    bit  seen;
    a_in  = a;
    b_in  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    seen  = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nbusy++;
        tick();
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    sub = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         ndone;
    int         dcyc [3];

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin    = 1'b0;
    sub    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);

    // 0x5A + 0x33, with a stray START during RUN and operands changed after acceptance
    exp_a = 8'h5a;
    exp_b = 8'h33;
    a_in  = 8'h5a;
    b_in  = 8'h33;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = 8'hff;
    b_in  = 8'hff;
    cin   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("run%0d_busy", i), 32'(busy), 32'd1);
      check($sformatf("run%0d_done", i), 32'(done), 32'd0);
      check($sformatf("run%0d_fa_a", i), 32'(fa_a), 32'(exp_a[i]));
      check($sformatf("run%0d_fa_b", i), 32'(fa_b), 32'(exp_b[i]));
      if (i == 3) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_sum", 32'(sum_out), 32'h8d);
    check("fin_cout", 32'(cout), 32'd0);
    check("fin_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_sum_held", 32'(sum_out), 32'h8d);
    ndone = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) ndone++;
      tick();
    end
    check("stray_start_dones", 32'(ndone), 32'd0);

    run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, "add_0_0_c1");
    run_op(8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run_op(8'hff, 8'hff, 1'b1, 1'b0, 8'hff, 1'b1, "add_ff_ff_c1");

    // Reset in the middle of RUN aborts without DONE and clears the result
    a_in  = 8'hff;
    b_in  = 8'hff;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum_out), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_dones", 32'(ndone), 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, "after_abort");

    // START held high: one operation every 10 cycles
    a_in  = 8'h01;
    b_in  = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    ndone = 0;
    for (int t = 0; t < 35; t++) begin
      if (done) begin
        if (ndone < 3) dcyc[ndone] = t;
        ndone++;
        check($sformatf("b2b_sum_t%0d", t), 32'(sum_out), 32'h02);
      end
      tick();
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    if (ndone >= 3) begin
      check("b2b_first", 32'(dcyc[0]), 32'd9);
      check("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd10);
      check("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd10);
    end
    repeat (12) tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);

`ifdef SERIAL_SUBTRACT_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0f, 1'b1, "sub_10_01");
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 8'hff, 1'b0, "sub_01_02");
    run_op(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, "sub_off_add");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
